// File: rtl/adxl362_ascii_cmd_pkg.sv
// Shared types and ASCII constants for the ADXL362 ASCII command parser.
package adxl362_ascii_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIGITS  = 2'd1,
    DISCARD = 2'd2,
    PEND    = 2'd3
  } t_parse_state;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_W_UC = 8'h57;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;

  // Digits needed after the opcode: two address digits, plus two data digits for writes.
  localparam logic [2:0] NEED_WRITE = 3'd4;
  localparam logic [2:0] NEED_READ  = 3'd2;
  localparam logic [2:0] CNT_MAX    = 3'd5;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/adxl362_ascii_cmd_parser_hex_decoder.sv
// ASCII hex digit to nibble; inverse of the display path's nibble-to-ASCII function.
module ascii_hex_digit_decoder (
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Decode '0'-'9', 'A'-'F' and 'a'-'f'; anything else reports not-hex with nibble 0.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ascii[3:0];
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) || (ascii >= 8'h61 && ascii <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/adxl362_ascii_cmd_parser.sv
// Parses "W aa dd <EOL>" / "R aa <EOL>" ASCII lines from the UART RX into
// register commands for the ADXL362 SPI command FSM.
//
// state   | meaning
// IDLE    | waiting for an opcode; empty lines and spaces ignored
// DIGITS  | opcode latched, collecting hex digits into the shift register
// DISCARD | malformed line already flagged; swallow bytes until EOL
// PEND    | command presented on o_cmd_*, waiting for i_cmd_ready
module adxl362_ascii_cmd_parser
  import adxl362_ascii_cmd_pkg::*;
#(
  parameter logic [7:0] parm_max_addr = 8'h2E
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rst_20mhz,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic       o_cmd_write,
  output logic [7:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  output logic       o_cmd_error,
  output logic       o_overrun
);

  t_parse_state state, state_nx;
  logic        op_write, op_write_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [15:0] sr, sr_nx;
  logic        valid_nx, write_nx, error_nx, overrun_nx;
  logic [7:0]  addr_nx, data_nx;

  logic        rx_is_hex;
  logic [3:0]  rx_nibble;
  logic [2:0]  need;
  logic [2:0]  cnt_inc;
  logic [7:0]  parse_addr;
  logic        rx_is_op_w, rx_is_op_r;

  ascii_hex_digit_decoder u_hex (
    .ascii  (i_rx_data),
    .is_hex (rx_is_hex),
    .nibble (rx_nibble)
  );

  assign need       = op_write ? NEED_WRITE : NEED_READ;
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 3'd1;
  assign parse_addr = op_write ? sr[15:8] : sr[7:0];
  assign rx_is_op_w = (i_rx_data == ASCII_W_UC) || (i_rx_data == ASCII_W_LC);
  assign rx_is_op_r = (i_rx_data == ASCII_R_UC) || (i_rx_data == ASCII_R_LC);

  // Next-state and next-output logic; errors and overruns are single-cycle pulses.
  always_comb begin
    state_nx    = state;
    op_write_nx = op_write;
    cnt_nx      = cnt;
    sr_nx       = sr;
    valid_nx    = o_cmd_valid;
    write_nx    = o_cmd_write;
    addr_nx     = o_cmd_addr;
    data_nx     = o_cmd_data;
    error_nx    = 1'b0;
    overrun_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (rx_is_op_w || rx_is_op_r) begin
            op_write_nx = rx_is_op_w;
            cnt_nx      = 3'd0;
            sr_nx       = 16'h0000;
            state_nx    = DIGITS;
          end else if (!is_eol(i_rx_data) && i_rx_data != ASCII_SP) begin
            error_nx = 1'b1;
            state_nx = DISCARD;
          end
        end
      end

      DIGITS: begin
        if (i_rx_valid && i_rx_data != ASCII_SP) begin
          if (rx_is_hex) begin
            sr_nx  = {sr[11:0], rx_nibble};
            cnt_nx = cnt_inc;
            if (cnt_inc > need) begin
              error_nx = 1'b1;
              state_nx = DISCARD;
            end
          end else if (is_eol(i_rx_data)) begin
            if (cnt == need && parse_addr <= parm_max_addr) begin
              valid_nx = 1'b1;
              write_nx = op_write;
              addr_nx  = parse_addr;
              data_nx  = op_write ? sr[7:0] : 8'h00;
              state_nx = PEND;
            end else begin
              error_nx = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            error_nx = 1'b1;
            state_nx = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (i_rx_valid && is_eol(i_rx_data)) state_nx = IDLE;
      end

      PEND: begin
        overrun_nx = i_rx_valid;
        if (i_cmd_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any partial line or pending command.
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state       <= IDLE;
      op_write    <= 1'b0;
      cnt         <= 3'd0;
      sr          <= 16'h0000;
      o_cmd_valid <= 1'b0;
      o_cmd_write <= 1'b0;
      o_cmd_addr  <= 8'h00;
      o_cmd_data  <= 8'h00;
      o_cmd_error <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_nx;
      op_write    <= op_write_nx;
      cnt         <= cnt_nx;
      sr          <= sr_nx;
      o_cmd_valid <= valid_nx;
      o_cmd_write <= write_nx;
      o_cmd_addr  <= addr_nx;
      o_cmd_data  <= data_nx;
      o_cmd_error <= error_nx;
      o_overrun   <= overrun_nx;
    end
  end

endmodule
